// File: rtl/pipe_in2out_fifo.sv
// rtl/pipe_in2out_fifo.sv - PipeIn-to-PipeOut elastic buffer, circular store of depth entries.
// Optional same-cycle empty bypass enabled by defining PIPE_IN2OUT_BYPASS_EN.
module pipe_in2out_fifo #(
   parameter int width = 32,
   parameter int depth = 4
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       in_enq_ena_i,
   input  logic [width-1:0]           in_enq_v_i,
   output logic                       in_enq_rdy_o,
   output logic [width-1:0]           out_first_o,
   output logic                       out_first_rdy_o,
   input  logic                       out_deq_ena_i,
   output logic                       out_deq_rdy_o,
   output logic [$clog2(depth+1)-1:0] count_o
);

   localparam int AW = $clog2(depth);
   localparam int CW = $clog2(depth+1);

   logic [width-1:0] mem_q [depth];
   logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             enq_fire, deq_fire, bypass, bypass_consume;

   always_comb begin
      in_enq_rdy_o = (cnt_q != CW'(depth));
`ifdef PIPE_IN2OUT_BYPASS_EN
      bypass = (cnt_q == '0) && in_enq_ena_i;
`else
      bypass = 1'b0;
`endif
      out_first_rdy_o = (cnt_q != '0) || bypass;
      out_deq_rdy_o   = out_first_rdy_o;
      out_first_o     = bypass ? in_enq_v_i : mem_q[rp_q];
      count_o         = cnt_q;

      enq_fire       = in_enq_ena_i && in_enq_rdy_o;
      deq_fire       = out_deq_ena_i && out_deq_rdy_o;
      // A bypassed value that is dequeued in the same cycle never lands in storage.
      bypass_consume = bypass && deq_fire;

      wp_d = enq_fire ? wp_q + AW'(1) : wp_q;
      rp_d = deq_fire ? rp_q + AW'(1) : rp_q;
      cnt_d = cnt_q;
      if (enq_fire && !deq_fire) begin
         cnt_d = cnt_q + CW'(1);
      end else if (deq_fire && !enq_fire) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge CLK or posedge nRST) begin
      if (nRST) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < depth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
         if (enq_fire && !bypass_consume) begin
            mem_q[wp_q] <= in_enq_v_i;
         end
      end
   end

endmodule

// File: tb/tb_pipe_in2out_fifo.sv
// tb/tb_pipe_in2out_fifo.sv - self-checking bench for pipe_in2out_fifo (vectors, corner sequences, random vs queue model).
module tb_pipe_in2out_fifo;

   localparam int W = 32;
   localparam int D = 4;
`ifdef PIPE_IN2OUT_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic         CLK = 1'b0;
   logic         nRST;
   logic         enq_ena, deq_ena;
   logic [W-1:0] enq_v;
   logic         enq_rdy, first_rdy, deq_rdy;
   logic [W-1:0] first;
   logic [2:0]   count;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] q[$];

   typedef struct {
      logic         enq;
      logic         deq;
      logic [W-1:0] v;
      int           cnt;
      logic         frdy;
      logic [W-1:0] first;
      logic         erdy;
   } vec_t;
   vec_t tv[8];

   pipe_in2out_fifo #(.width(W), .depth(D)) dut (
      .CLK            (CLK),
      .nRST           (nRST),
      .in_enq_ena_i   (enq_ena),
      .in_enq_v_i     (enq_v),
      .in_enq_rdy_o   (enq_rdy),
      .out_first_o    (first),
      .out_first_rdy_o(first_rdy),
      .out_deq_ena_i  (deq_ena),
      .out_deq_rdy_o  (deq_rdy),
      .count_o        (count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic e, input logic d, input logic [W-1:0] v);
      enq_ena = e;
      deq_ena = d;
      enq_v   = v;
   endtask

   task automatic check_model(input string tag);
      logic exp_frdy;
      exp_frdy = (q.size() != 0) || (BYP && enq_ena);
      chk({tag, "_enq_rdy"}, W'(enq_rdy), W'(q.size() != D));
      chk({tag, "_count"}, W'(count), W'(q.size()));
      chk({tag, "_first_rdy"}, W'(first_rdy), W'(exp_frdy));
      chk({tag, "_deq_rdy"}, W'(deq_rdy), W'(exp_frdy));
      if (exp_frdy) chk({tag, "_first"}, first, (q.size() != 0) ? q[0] : enq_v);
   endtask

   task automatic model_step();
      bit eok, dok;
      eok = enq_ena && (q.size() != D);
      dok = deq_ena && ((q.size() != 0) || (BYP && enq_ena));
      if (!(dok && q.size() == 0)) begin
         if (dok) void'(q.pop_front());
         if (eok) q.push_back(enq_v);
      end
   endtask

   initial begin
      // Fill to full, then enq+deq at full (only deq happens), then drain.
      tv[0] = '{1'b1, 1'b0, 32'd1, 1, 1'b1, 32'd1, 1'b1};
      tv[1] = '{1'b1, 1'b0, 32'd2, 2, 1'b1, 32'd1, 1'b1};
      tv[2] = '{1'b1, 1'b0, 32'd3, 3, 1'b1, 32'd1, 1'b1};
      tv[3] = '{1'b1, 1'b0, 32'd4, 4, 1'b1, 32'd1, 1'b0};
      tv[4] = '{1'b1, 1'b1, 32'd9, 3, 1'b1, 32'd2, 1'b1};
      tv[5] = '{1'b0, 1'b1, 32'd0, 2, 1'b1, 32'd3, 1'b1};
      tv[6] = '{1'b0, 1'b1, 32'd0, 1, 1'b1, 32'd4, 1'b1};
      tv[7] = '{1'b0, 1'b1, 32'd0, 0, 1'b0, 32'd0, 1'b1};

      nRST = 1'b1;
      drive(1'b0, 1'b0, '0);
      tick();
      tick();
      chk("rst_hold_count", W'(count), 0);
      chk("rst_hold_first_rdy", W'(first_rdy), 0);
      nRST = 1'b0;
      #1;
      chk("rst_enq_rdy", W'(enq_rdy), 1);
      chk("rst_first_rdy", W'(first_rdy), 0);
      chk("rst_deq_rdy", W'(deq_rdy), 0);
      chk("rst_first", first, 0);
      chk("rst_count", W'(count), 0);

      for (int i = 0; i < 8; i++) begin
         drive(tv[i].enq, tv[i].deq, tv[i].v);
         tick();
         drive(1'b0, 1'b0, '0);
         #1;
         chk($sformatf("vec%0d_count", i), W'(count), W'(tv[i].cnt));
         chk($sformatf("vec%0d_first_rdy", i), W'(first_rdy), W'(tv[i].frdy));
         chk($sformatf("vec%0d_enq_rdy", i), W'(enq_rdy), W'(tv[i].erdy));
         if (tv[i].frdy) chk($sformatf("vec%0d_first", i), first, tv[i].first);
      end

      // Streaming through pointer wrap at occupancy 1.
      drive(1'b1, 1'b0, 32'd100);
      tick();
      for (int i = 1; i <= 20; i++) begin
         drive(1'b1, 1'b1, W'(100 + i));
         tick();
         drive(1'b0, 1'b0, '0);
         #1;
         chk($sformatf("stream%0d_first", i), first, W'(100 + i));
         chk($sformatf("stream%0d_count", i), W'(count), 1);
      end
      drive(1'b0, 1'b1, '0);
      tick();
      drive(1'b0, 1'b0, '0);
      #1;
      chk("stream_drain_count", W'(count), 0);

      // Enq+deq at empty.
      drive(1'b1, 1'b1, 32'h3C);
      #1;
`ifdef PIPE_IN2OUT_BYPASS_EN
      chk("empty_byp_first_rdy", W'(first_rdy), 1);
      chk("empty_byp_first", first, 32'h3C);
      tick();
      drive(1'b0, 1'b0, '0);
      #1;
      chk("empty_byp_count", W'(count), 0);
      chk("empty_byp_after_rdy", W'(first_rdy), 0);
`else
      chk("empty_first_rdy", W'(first_rdy), 0);
      tick();
      drive(1'b0, 1'b0, '0);
      #1;
      chk("empty_count", W'(count), 1);
      chk("empty_first", first, 32'h3C);
      drive(1'b0, 1'b1, '0);
      tick();
      drive(1'b0, 1'b0, '0);
`endif

      // Reset mid-stream with 3 entries held.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, W'(50 + i));
         tick();
      end
      drive(1'b0, 1'b0, '0);
      #1;
      chk("mid_pre_count", W'(count), 3);
      nRST = 1'b1;
      #1;
      chk("mid_rst_count", W'(count), 0);
      chk("mid_rst_first_rdy", W'(first_rdy), 0);
      chk("mid_rst_enq_rdy", W'(enq_rdy), 1);
      chk("mid_rst_first", first, 0);
      tick();
      nRST = 1'b0;
      drive(1'b1, 1'b0, 32'hA5);
      tick();
      drive(1'b0, 1'b0, '0);
      #1;
      chk("post_rst_first", first, 32'hA5);
      chk("post_rst_first_rdy", W'(first_rdy), 1);

      // Randomized legal traffic against the queue model.
      nRST = 1'b1;
      tick();
      nRST = 1'b0;
      q.delete();
      for (int n = 0; n < 400; n++) begin
         logic e, d;
         e = ($urandom_range(0, 3) != 0) && (q.size() != D);
         d = ($urandom_range(0, 3) != 0) && ((q.size() != 0) || (BYP && e));
         drive(e, d, $urandom);
         #1;
         check_model($sformatf("rnd%0d", n));
         model_step();
         tick();
      end
      drive(1'b0, 1'b0, '0);
      #1;
      check_model("rnd_end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
